// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU / LSU) for the single register file write port.
// Optional read bypass of the in-flight write is enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req0_valid,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [DW-1:0] i_req0_data,
  output logic          o_req0_ready,
  input  logic          i_req1_valid,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [DW-1:0] i_req1_data,
  output logic          o_req1_ready,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  input  logic [AW-1:0] i_rd_addr1,
  input  logic [AW-1:0] i_rd_addr2,
  input  logic [DW-1:0] i_rd_data1,
  input  logic [DW-1:0] i_rd_data2,
  output logic [DW-1:0] o_rd_data1,
  output logic [DW-1:0] o_rd_data2
);

  logic          last_reg;
  logic          last_next;
  logic          grant0;
  logic          grant1;
  logic          grant_any;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          wr_en_reg;
  logic          wr_en_next;
  logic [AW-1:0] wr_addr_reg;
  logic [AW-1:0] wr_addr_next;
  logic [DW-1:0] wr_data_reg;
  logic [DW-1:0] wr_data_next;

  // Under contention the port that did not win last time gets the grant.
  always_comb begin
    grant0 = i_req0_valid && (!i_req1_valid || last_reg);
    grant1 = i_req1_valid && (!i_req0_valid || !last_reg);
  end

  assign grant_any    = grant0 || grant1;
  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  always_comb begin
    sel_addr = grant1 ? i_req1_addr : i_req0_addr;
    sel_data = grant1 ? i_req1_data : i_req0_data;
  end

  always_comb begin
    last_next    = last_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    if (grant_any) begin
      last_next    = grant1;
      // Writes to x0 are accepted and registered but never enabled.
      wr_en_next   = (sel_addr != '0);
      wr_addr_next = sel_addr;
      wr_data_next = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg    <= 1'b1;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      last_reg    <= last_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign o_wr_en   = wr_en_reg;
  assign o_wr_addr = wr_addr_reg;
  assign o_wr_data = wr_data_reg;

  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_raw  [2];
  logic [DW-1:0] rd_out  [2];

  assign rd_addr[0] = i_rd_addr1;
  assign rd_addr[1] = i_rd_addr2;
  assign rd_raw[0]  = i_rd_data1;
  assign rd_raw[1]  = i_rd_data2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef WB_BYPASS_EN
      logic hit;
      assign hit        = wr_en_reg && (rd_addr[gi] == wr_addr_reg);
      assign rd_out[gi] = hit ? wr_data_reg : rd_raw[gi];
`else
      logic [AW-1:0] unused_addr;
      assign unused_addr = rd_addr[gi];
      assign rd_out[gi]  = rd_raw[gi];
`endif
    end
  endgenerate

  assign o_rd_data1 = rd_out[0];
  assign o_rd_data2 = rd_out[1];

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter sitting in front of the single write port of the 32x32 register file in the 05_cpu core. Two write-back sources (port 0: ALU, port 1: LSU) each present a valid/ready write request. The block grants one per cycle round-robin, registers the winning write and drives the register file write port. It can also forward the in-flight write to the register file read ports.

## Interface
Parameters:
- AW, 5, register address width (32 registers)
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req0_valid  in  1  port 0 (ALU) write request
- i_req0_addr  in  AW  port 0 destination register
- i_req0_data  in  DW  port 0 write data
- o_req0_ready  out  1  port 0 granted this cycle
- i_req1_valid / i_req1_addr / i_req1_data / o_req1_ready  same as port 0, for port 1 (LSU)
- o_wr_en  out  1  register file write enable
- o_wr_addr  out  AW  register file write address
- o_wr_data  out  DW  register file write data
- i_rd_addr1, i_rd_addr2  in  AW  register file read addresses (bypass compare)
- i_rd_data1, i_rd_data2  in  DW  raw register file read data
- o_rd_data1, o_rd_data2  out  DW  read data after optional bypass

## Operation
- Handshake: transfer on a port when valid && ready in the same cycle. A requester holds valid, addr and data stable until ready. Ready is a combinational function of both valids and the priority pointer. Ready is never asserted while that port's valid is low.
- Grant:
  - Only one valid: that port is granted.
  - Both valid: the port other than `last` is granted.
  - Neither valid: no grant; both readies low.
- `last` is a 1-bit register. It updates to the granted port index on every grant. Reset value is 1, so port 0 wins the first contention.
- Exactly one grant per cycle, max. The register file never stalls, so throughput is one write per cycle.
- Output stage, on each grant:
  - Registers addr and data into o_wr_addr/o_wr_data.
  - Sets o_wr_en = 1, except for addr == 0 (x0): the request is still accepted (ready high) but o_wr_en = 0.
  - When there is no grant, o_wr_en = 0 and o_wr_addr/o_wr_data hold their previous values.
- Reset mid-operation: all registers return to reset values immediately. Any write captured but not yet presented is lost. Requesters must re-present their requests after reset.

## Timing
- Reset values: o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0, last = 1. o_req0_ready and o_req1_ready are 0 whenever both valids are 0.
- Latency:
  - Handshake in cycle N gives o_wr_en/addr/data valid in cycle N+1.
  - The register file is updated at the rising edge ending cycle N+1.
  - A read of that register sees the new value from cycle N+2 without bypass.
- Back-to-back: grants in consecutive cycles produce o_wr_en high in consecutive cycles, with no bubble.
- Contention: with both ports valid continuously, grants alternate 0,1,0,1… starting with port 0 after reset.
- Same destination from both ports in consecutive grants: the later grant's data lands last, in grant order.

## Configuration
- WB_BYPASS_EN defined:
  - o_rd_dataK = o_wr_data when o_wr_en && i_rd_addrK == o_wr_addr; otherwise o_rd_dataK = i_rd_dataK. This path is purely combinational.
  - x0 never matches, because o_wr_en is low for x0.
- WB_BYPASS_EN undefined: o_rd_dataK = i_rd_dataK and the compare logic is absent. Consumers must tolerate the one-cycle stale window.

## Test plan
- Reset: assert rst_n = 0 asynchronously mid-cycle with both ports valid -> o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0 immediately; after release, the first contended grant goes to port 0.
- Single requester: port 1 valid with addr = 5, data = 0xDEADBEEF in cycle N -> o_req1_ready = 1 in cycle N; o_wr_en = 1, o_wr_addr = 5, o_wr_data = 0xDEADBEEF in cycle N+1; o_wr_en = 0 in N+2 if idle.
- Contention: both ports valid for 4 cycles with distinct addresses 1..4 -> grants 0,1,0,1; o_wr_en high for 4 consecutive cycles; both queues drained in order.
- x0 write: port 0 valid with addr = 0, data = 0x1234 -> o_req0_ready = 1; o_wr_en stays 0 in the next cycle.
- Bypass (WB_BYPASS_EN): grant addr = 7, data = 0xA5A5A5A5 in N; in N+1 drive i_rd_addr1 = 7, i_rd_data1 = 0 -> o_rd_data1 = 0xA5A5A5A5. Same stimulus without the macro -> o_rd_data1 = 0.
- Fairness under hold: port 0 valid continuously, port 1 valid asserted at cycle 3 -> port 1 granted within 1 cycle of assertion; port 0 is not granted twice in a row while port 1 is waiting.
